// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, entry type and helpers for the fetch stage
//
// Purpose : constants and types used by inst_fetch and fetch_fifo.
//   InstAddrBus / InstBus : default instruction address / word widths
//   FETCH_DEPTH           : default prefetch depth (in-flight + buffered)
//   fetch_entry_t         : {pc, inst, exc} record held in the prefetch FIFO
//   cnt_width()           : bits needed to count 0..depth inclusive

package fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int FETCH_DEPTH = 2;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
    logic                   exc;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous DEPTH-entry FIFO with push/pop/flush/count
//
// Purpose : small register FIFO; first-word-fall-through head output.
// Params  : DEPTH (power of two, >= 2), T (stored element type)
// Ports   :
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored while full)
//   push_data  : element to write
//   pop        : drop the head element (ignored while empty)
//   flush      : empty the FIFO next cycle; wins over push/pop
//   head       : current head element, valid while count != 0
//   count      : number of stored elements, 0..DEPTH

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = FETCH_DEPTH,
  parameter type T     = fetch_entry_t,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & (count != FULL_CNT);
  assign pop_ok  = pop & (count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; entries are only observed once counted in.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with variable-latency memory and prefetch FIFO
//
// Purpose : accepts PCs (valid/ready), issues in-order instruction memory
//           requests, buffers {pc, inst, exc} responses and presents them to
//           decode (valid/ready). flush_i discards everything fetched or in flight.
// Macro   : FETCH_ALIGN_CHECK_EN - when defined, a misaligned PC (pc_i[1:0]!=0)
//           is not sent to memory; an exception entry {pc, 0, 1} is queued instead.
//           When undefined id_exc_o is tied to 0.
// Params  : DEPTH (in-flight + buffered fetches, power of two >= 2), AW, DW
// Ports   :
//   clk, rst                        : clock, synchronous active-high reset
//   pc_i, pc_valid_i, pc_ready_o    : PC stream in; ready = PC consumed this cycle
//   imem_req_o, imem_addr_o         : memory request / address
//   imem_gnt_i                      : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i     : in-order response, >= 1 cycle after grant
//   flush_i                         : drop all buffered and in-flight fetches
//   id_valid_o, id_pc_o, id_inst_o,
//   id_exc_o, id_ready_i            : decode-side entry handshake

module inst_fetch
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int AW    = InstAddrBus,
  parameter int DW    = InstBus
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          pc_valid_i,
  output logic          pc_ready_o,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  input  logic          flush_i,
  output logic          id_valid_o,
  output logic [AW-1:0] id_pc_o,
  output logic [DW-1:0] id_inst_o,
  output logic          id_exc_o,
  input  logic          id_ready_i
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    logic          exc;
  } entry_t;

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] unused_pcq_cnt;
  logic [AW-1:0] pcq_head;
  logic          credit;
  logic          misalign;
  logic          align_take;
  logic          grant;
  logic          resp_keep;
  logic          fifo_push;
  logic          id_pop;
  entry_t        fifo_in;
  entry_t        fifo_head;

  // Outstanding requests plus buffered entries never exceed DEPTH, so every
  // response already has a FIFO slot reserved and the FIFO cannot overflow.
  assign credit = ({1'b0, out_cnt} + {1'b0, fifo_cnt}) < DEPTH_L;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign   = pc_valid_i & (pc_i[1:0] != 2'b00);
  // Only taken with nothing in flight, so the exception entry lands behind
  // every older instruction.
  assign align_take = misalign & credit & ~flush_i & ~rst & (out_cnt == '0);
`else
  assign misalign   = 1'b0;
  assign align_take = 1'b0;
`endif

  assign imem_req_o  = pc_valid_i & credit & ~flush_i & ~misalign & ~rst;
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o & imem_gnt_i;
  assign pc_ready_o  = grant | align_take;

  // Responses owed to flushed requests are swallowed; so is any response
  // arriving in the flush cycle itself.
  assign resp_keep = imem_rvalid_i & (drop_cnt == '0) & ~flush_i;
  assign fifo_push = resp_keep | align_take;
  assign id_pop    = id_valid_o & id_ready_i;

  always_comb begin
    fifo_in = '0;
    if (align_take) begin
      fifo_in.pc  = pc_i;
      fifo_in.exc = 1'b1;
    end else begin
      fifo_in.pc   = pcq_head;
      fifo_in.inst = imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case ({grant, imem_rvalid_i})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: ;
      endcase
      // No grant is possible during flush, so everything still outstanding
      // after this cycle's response (if any) must be dropped.
      if (flush_i) begin
        drop_cnt <= out_cnt - CW'(imem_rvalid_i);
      end else if (imem_rvalid_i && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Addresses of granted requests; never flushed, drained by responses
  // (kept or dropped) so the head always matches the returning data.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [AW-1:0])
  ) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (pc_i),
    .pop       (imem_rvalid_i),
    .flush     (1'b0),
    .head      (pcq_head),
    .count     (unused_pcq_cnt)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_entry_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (id_pop),
    .flush     (flush_i),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  assign id_valid_o = (fifo_cnt != '0);
  assign id_pc_o    = fifo_head.pc;
  assign id_inst_o  = fifo_head.inst;

`ifdef FETCH_ALIGN_CHECK_EN
  assign id_exc_o = fifo_head.exc;
`else
  logic unused_exc;
  assign unused_exc = fifo_head.exc;
  assign id_exc_o   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking directed bench for inst_fetch

module tb_inst_fetch;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_i;
  logic          pc_valid_i;
  logic          pc_ready_o;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_gnt_i;
  logic          imem_rvalid_i;
  logic [DW-1:0] imem_rdata_i;
  logic          flush_i;
  logic          id_valid_o;
  logic [AW-1:0] id_pc_o;
  logic [DW-1:0] id_inst_o;
  logic          id_exc_o;
  logic          id_ready_i;

  always #5 clk = ~clk;

  inst_fetch #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .flush_i       (flush_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_exc_o      (id_exc_o),
    .id_ready_i    (id_ready_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mem_lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [31:0] gnt_pc[$];
  int          gnt_cyc[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_inst[$];
  logic        acc_exc[$];
  int          acc_cyc[$];
  logic [31:0] feed_pcs[8];
  int          feed_idx;

  // Memory model and decode-side monitor; sampled at the edge before the DUT updates.
  always @(posedge clk) begin : mon
    int c;
    c = cyc + 1;
    if (rst) begin
      mq.delete();
    end else begin
      if (imem_rvalid_i && mq.size() > 0) mq.delete(0);
      if (imem_req_o && imem_gnt_i) begin
        mq.push_back('{imem_addr_o, c + mem_lat});
        gnt_pc.push_back(imem_addr_o);
        gnt_cyc.push_back(c);
      end
      if (id_valid_o && id_ready_i) begin
        acc_pc.push_back(id_pc_o);
        acc_inst.push_back(id_inst_o);
        acc_exc.push_back(id_exc_o);
        acc_cyc.push_back(c);
      end
    end
    cyc = c;
  end

  // Memory returns ~addr as the instruction word.
  always @(negedge clk) begin
    if (!rst && mq.size() > 0 && mq[0].due <= cyc + 1) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = ~mq[0].addr;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pc_valid_i = 1'b0; pc_i = '0; imem_gnt_i = 1'b1;
    flush_i = 1'b0; id_ready_i = 1'b0; mem_lat = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gnt_pc.delete(); gnt_cyc.delete();
    acc_pc.delete(); acc_inst.delete(); acc_exc.delete(); acc_cyc.delete();
  endtask

  task automatic feed(input int n, input int n_acc, input int budget);
    int k;
    k = 0;
    while ((feed_idx < n || acc_pc.size() < n_acc) && k < budget) begin
      @(negedge clk);
      pc_valid_i = (feed_idx < n);
      pc_i = (feed_idx < n) ? feed_pcs[feed_idx] : '0;
      #1;
      if (pc_ready_o) feed_idx++;
      k++;
    end
    pc_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    imem_gnt_i = 1'b1; id_ready_i = 1'b0;
    repeat (4) begin
      @(negedge clk); pc_valid_i = 1'b1; pc_i = 32'h40;
    end
    @(negedge clk); pc_valid_i = 1'b0; #1;
    n_cmp++; if (id_valid_o !== 1'b1) begin n_bad++; $display("FAIL reset_prefill_valid: got %b want 1", id_valid_o); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid: got %b want 0", id_valid_o); end
    rst = 1'b0; #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    n_cmp++; if (pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_pc_ready: got %b want 0", pc_ready_o); end
    pc_valid_i = 1'b1; pc_i = 32'h44; #1;
    n_cmp++; if (imem_req_o !== 1'b1) begin n_bad++; $display("FAIL reset_credit_restored: got %b want 1", imem_req_o); end
    n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_empty: got %b want 0", id_valid_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    id_ready_i = 1'b1;
    feed_pcs[0] = 32'h0; feed_pcs[1] = 32'h4; feed_pcs[2] = 32'h8;
    feed_idx = 0;
    feed(3, 3, 30);
    n_cmp++; if (acc_pc.size() != 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", acc_pc.size()); end
    for (int i = 0; i < acc_pc.size() && i < 3; i++) begin
      n_cmp++; if (acc_pc[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, acc_pc[i], 32'(4 * i)); end
      n_cmp++; if (acc_inst[i] !== ~32'(4 * i)) begin n_bad++; $display("FAIL b2b_inst[%0d]: got %h want %h", i, acc_inst[i], ~32'(4 * i)); end
    end
    if (acc_cyc.size() >= 2 && gnt_cyc.size() >= 1) begin
      n_cmp++; if (acc_cyc[0] - gnt_cyc[0] != 2) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 2", acc_cyc[0] - gnt_cyc[0]); end
      n_cmp++; if (acc_cyc[1] - acc_cyc[0] != 1) begin n_bad++; $display("FAIL b2b_consecutive: got %0d want 1", acc_cyc[1] - acc_cyc[0]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    id_ready_i = 1'b0;
    feed_pcs[0] = 32'h0; feed_pcs[1] = 32'h4; feed_pcs[2] = 32'h8; feed_pcs[3] = 32'hC;
    feed_idx = 0;
    repeat (6) begin
      @(negedge clk);
      pc_valid_i = (feed_idx < 4);
      pc_i = feed_pcs[feed_idx];
      #1;
      if (id_valid_o) begin
        n_cmp++; if (id_pc_o !== 32'h0) begin n_bad++; $display("FAIL stall_hold_pc: got %h want 00000000", id_pc_o); end
      end
      if (pc_ready_o) feed_idx++;
    end
    n_cmp++; if (gnt_pc.size() != 2) begin n_bad++; $display("FAIL stall_grants: got %0d want 2", gnt_pc.size()); end
    n_cmp++; if (pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_pc_ready: got %b want 0", pc_ready_o); end
    n_cmp++; if (id_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", id_valid_o); end
    id_ready_i = 1'b1;
    feed(4, 4, 40);
    n_cmp++; if (acc_pc.size() != 4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", acc_pc.size()); end
    for (int i = 0; i < acc_pc.size() && i < 4; i++) begin
      n_cmp++; if (acc_pc[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL stall_order[%0d]: got %h want %h", i, acc_pc[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_gnt_low();
    do_reset();
    id_ready_i = 1'b1; imem_gnt_i = 1'b0;
    repeat (3) begin
      @(negedge clk); pc_valid_i = 1'b1; pc_i = 32'h10; #1;
      n_cmp++; if (imem_req_o !== 1'b1) begin n_bad++; $display("FAIL gntlow_req: got %b want 1", imem_req_o); end
      n_cmp++; if (imem_addr_o !== 32'h10) begin n_bad++; $display("FAIL gntlow_addr: got %h want 00000010", imem_addr_o); end
      n_cmp++; if (pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL gntlow_pc_ready: got %b want 0", pc_ready_o); end
    end
    n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL gntlow_no_entry: got %b want 0", id_valid_o); end
    imem_gnt_i = 1'b1;
    feed_pcs[0] = 32'h10; feed_idx = 0;
    feed(1, 1, 20);
    n_cmp++; if (acc_pc.size() != 1) begin n_bad++; $display("FAIL gntlow_count: got %0d want 1", acc_pc.size()); end
    if (acc_pc.size() > 0) begin
      n_cmp++; if (acc_pc[0] !== 32'h10) begin n_bad++; $display("FAIL gntlow_pc: got %h want 00000010", acc_pc[0]); end
      n_cmp++; if (acc_inst[0] !== 32'hFFFF_FFEF) begin n_bad++; $display("FAIL gntlow_inst: got %h want ffffffef", acc_inst[0]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    mem_lat = 4; id_ready_i = 1'b1;
    @(negedge clk); pc_valid_i = 1'b1; pc_i = 32'h20; #1;
    n_cmp++; if (pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_issue0: got %b want 1", pc_ready_o); end
    @(negedge clk); pc_i = 32'h24; #1;
    n_cmp++; if (pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_issue1: got %b want 1", pc_ready_o); end
    @(negedge clk); flush_i = 1'b1; pc_i = 32'h100; #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL flush_no_req: got %b want 0", imem_req_o); end
    n_cmp++; if (pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_no_ready: got %b want 0", pc_ready_o); end
    @(negedge clk); flush_i = 1'b0; pc_valid_i = 1'b0;
    feed_pcs[0] = 32'h100; feed_idx = 0;
    feed(1, 1, 40);
    repeat (6) @(negedge clk);
    n_cmp++; if (acc_pc.size() != 1) begin n_bad++; $display("FAIL flush_count: got %0d want 1", acc_pc.size()); end
    if (acc_pc.size() > 0) begin
      n_cmp++; if (acc_pc[0] !== 32'h100) begin n_bad++; $display("FAIL flush_next_pc: got %h want 00000100", acc_pc[0]); end
      n_cmp++; if (acc_inst[0] !== 32'hFFFF_FEFF) begin n_bad++; $display("FAIL flush_next_inst: got %h want fffffeff", acc_inst[0]); end
    end
  endtask

  task automatic test_flush_rvalid();
    do_reset();
    mem_lat = 1; id_ready_i = 1'b0;
    @(negedge clk); pc_valid_i = 1'b1; pc_i = 32'h30; #1;
    n_cmp++; if (pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL frv_issue0: got %b want 1", pc_ready_o); end
    @(negedge clk); pc_i = 32'h20; #1;
    n_cmp++; if (pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL frv_issue1: got %b want 1", pc_ready_o); end
    @(negedge clk); pc_valid_i = 1'b0; flush_i = 1'b1; #1;
    n_cmp++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h30) begin n_bad++; $display("FAIL frv_pre_flush: got %b/%h want 1/00000030", id_valid_o, id_pc_o); end
    @(negedge clk); flush_i = 1'b0; #1;
    n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL frv_emptied: got %b want 0", id_valid_o); end
    id_ready_i = 1'b1;
    feed_pcs[0] = 32'h40; feed_idx = 0;
    feed(1, 1, 20);
    repeat (4) @(negedge clk);
    n_cmp++; if (acc_pc.size() != 1) begin n_bad++; $display("FAIL frv_count: got %0d want 1", acc_pc.size()); end
    if (acc_pc.size() > 0) begin
      n_cmp++; if (acc_pc[0] !== 32'h40) begin n_bad++; $display("FAIL frv_next_pc: got %h want 00000040", acc_pc[0]); end
    end
  endtask

  task automatic test_align();
    do_reset();
`ifdef FETCH_ALIGN_CHECK_EN
    id_ready_i = 1'b0;
    @(negedge clk); pc_valid_i = 1'b1; pc_i = 32'h6; #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL align_no_req: got %b want 0", imem_req_o); end
    n_cmp++; if (pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL align_pc_ready: got %b want 1", pc_ready_o); end
    @(negedge clk); pc_valid_i = 1'b0; #1;
    n_cmp++; if (id_valid_o !== 1'b1) begin n_bad++; $display("FAIL align_valid: got %b want 1", id_valid_o); end
    n_cmp++; if (id_pc_o !== 32'h6) begin n_bad++; $display("FAIL align_pc: got %h want 00000006", id_pc_o); end
    n_cmp++; if (id_exc_o !== 1'b1) begin n_bad++; $display("FAIL align_exc: got %b want 1", id_exc_o); end
    n_cmp++; if (id_inst_o !== 32'h0) begin n_bad++; $display("FAIL align_inst: got %h want 00000000", id_inst_o); end
    n_cmp++; if (gnt_pc.size() != 0) begin n_bad++; $display("FAIL align_grants: got %0d want 0", gnt_pc.size()); end
`else
    id_ready_i = 1'b1;
    feed_pcs[0] = 32'h6; feed_idx = 0;
    feed(1, 1, 20);
    n_cmp++; if (acc_pc.size() != 1) begin n_bad++; $display("FAIL align_count: got %0d want 1", acc_pc.size()); end
    if (acc_pc.size() > 0) begin
      n_cmp++; if (acc_pc[0] !== 32'h6) begin n_bad++; $display("FAIL align_pc: got %h want 00000006", acc_pc[0]); end
      n_cmp++; if (acc_exc[0] !== 1'b0) begin n_bad++; $display("FAIL align_exc: got %b want 0", acc_exc[0]); end
      n_cmp++; if (acc_inst[0] !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL align_inst: got %h want fffffff9", acc_inst[0]); end
    end
`endif
  endtask

  initial begin
    rst = 1'b1; pc_valid_i = 1'b0; pc_i = '0; imem_gnt_i = 1'b0;
    flush_i = 1'b0; id_ready_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_gnt_low();
    test_flush();
    test_flush_rvalid();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage directly downstream of the PC register.
- Takes the PC stream with a valid/ready handshake and issues in-order requests to instruction memory.
- Memory latency is variable: grant, then rvalid one or more cycles later.
- Buffers returned {pc, inst} pairs in a small prefetch FIFO. Presents them to the IF/ID boundary with valid/ready. Supports a pipeline flush.

Parameters:
- DEPTH, 2, max in-flight plus buffered fetches; power of two, at least 2.
- AW, 32, instruction address width (InstAddrBus).
- DW, 32, instruction word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pc_i  in  AW  next fetch address
- pc_valid_i  in  1  pc_i valid (PC register chip-enable)
- pc_ready_o  out  1  pc_i consumed this cycle; PC may advance
- imem_req_o  out  1  memory request
- imem_addr_o  out  AW  request address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; in order, at least 1 cycle after grant
- imem_rdata_i  in  DW  response data
- flush_i  in  1  discard all fetched and in-flight instructions
- id_valid_o  out  1  entry available to decode
- id_pc_o  out  AW  PC of entry
- id_inst_o  out  DW  instruction of entry
- id_exc_o  out  1  fetch exception flag (see Optional Feature)
- id_ready_i  in  1  decode accepts entry

Behaviour:
State:
- out_cnt: outstanding requests, 0..DEPTH.
- drop_cnt: responses to discard, 0..DEPTH.
- pc_q: DEPTH-entry address queue of granted PCs.
- FIFO: DEPTH entries of {pc, inst, exc}, with count fifo_cnt.

Reset (rst=1 at posedge): out_cnt=0, drop_cnt=0, FIFO and pc_q empty. Consequently id_valid_o=0, imem_req_o=0, pc_ready_o=0. Data outputs are don't-care while not valid.

Issue rules:
- credit = (out_cnt + fifo_cnt) < DEPTH.
- imem_req_o = pc_valid_i & credit & ~flush_i.
- imem_addr_o = pc_i.
- pc_ready_o = imem_req_o & imem_gnt_i. The PC is consumed only on grant.
- On grant: push pc_i to pc_q, out_cnt+1.

Response rules:
- On imem_rvalid_i: pop pc_q, out_cnt-1.
- If drop_cnt>0: discard the response, drop_cnt-1.
- Otherwise push {pc_q head, imem_rdata_i, 0} into the FIFO.
- No bypass: a response is visible on id_* the cycle after rvalid.
- Minimum latency from grant to id_valid_o is 2 cycles.

Output rules:
- id_valid_o = fifo_cnt != 0. id_* shows the FIFO head.
- Pop on id_valid_o & id_ready_i.
- id_* is held stable while id_valid_o=1 and id_ready_i=0.

Counter rules:
- Grant and rvalid in the same cycle: out_cnt unchanged; pc_q pushes and pops together.
- Push and pop in the same cycle: fifo_cnt unchanged.
- The credit rule makes FIFO overflow impossible.

Flush (flush_i=1):
- FIFO emptied next cycle, so id_valid_o=0 next cycle.
- No request is issued this cycle.
- drop_cnt <= out_cnt - (rvalid this cycle & drop_cnt==0 ? 1 : 0) + drop_cnt adjustment. The net effect: every response not yet returned is dropped.
- pc_q is not cleared; its entries drain with the dropped responses.
- A response arriving in the flush cycle is discarded.
- Flush and reset together: reset wins.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - pc_valid_i with pc_i[1:0]!=0 and credit available: no memory request is made.
  - pc_ready_o=1 that cycle. A FIFO entry {pc_i, 0, 1} is pushed in order.
  - This happens only when out_cnt==0, otherwise the PC stalls, so ordering is preserved.
- Undefined: no alignment check; id_exc_o is tied to 0.

Decomposition:
- Package fetch_pkg: typedef fetch_entry_t {pc, inst, exc}; AW/DW constants aliased to InstAddrBus/InstBus widths; constant FETCH_DEPTH.
- One sub-module, fetch_fifo: a synchronous DEPTH-entry FIFO of fetch_entry_t with push/pop/flush/count. Instantiated for the entry FIFO; pc_q reuses it with exc/inst unused.

Test Plan:
- Back-to-back, gnt=1, rvalid 1 cycle after grant, id_ready=1, pc 0x0,0x4,0x8 -> id_pc 0x0,0x4,0x8 on consecutive cycles; first id_valid 2 cycles after first grant.
- id_ready=0 for 5 cycles, DEPTH=2 -> exactly 2 grants, then pc_ready_o=0; id_pc_o held at 0x0; after release, sequence resumes at 0x8 with no loss.
- gnt low for 3 cycles with pc_valid=1 -> imem_addr_o held at 0x10, pc_ready_o=0, no FIFO entry.
- Two outstanding requests (0x20, 0x24), flush_i pulsed, then pc 0x100 issued -> both old responses dropped; the next id_pc_o is 0x100.
- Flush in the same cycle as rvalid for 0x20 -> 0x20 never appears on id_*; drop_cnt returns to 0.
- FETCH_ALIGN_CHECK_EN with pc 0x6 -> no imem_req_o; id_valid_o=1, id_pc_o=0x6, id_exc_o=1, id_inst_o=0.
